// File: rtl/kronos_branch_resolve.sv
// Execute-stage branch resolution: condition compare, target/link generation,
// a one-entry result register, fetch redirect and wrong-path squashing.

// Condition comparator for conditional branches, keyed by funct3.
module kronos_branch (
   input  logic [2:0]  op,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   output logic        taken
);
   // Unused funct3 encodings (010/011) never take.
   always_comb begin
      taken = 1'b0;
      case (op)
         3'b000:  taken = (rs1 == rs2);
         3'b001:  taken = (rs1 != rs2);
         3'b100:  taken = ($signed(rs1) <  $signed(rs2));
         3'b101:  taken = ($signed(rs1) >= $signed(rs2));
         3'b110:  taken = (rs1 <  rs2);
         3'b111:  taken = (rs1 >= rs2);
         default: taken = 1'b0;
      endcase
   end
endmodule

module kronos_branch_resolve #(
   parameter bit CATCH_MISALIGN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dec_vld,
   output logic        dec_rdy,
   input  logic [1:0]  dec_kind,
   input  logic [2:0]  dec_op,
   input  logic [31:0] dec_pc,
   input  logic [31:0] dec_imm,
   input  logic [31:0] dec_rs1,
   input  logic [31:0] dec_rs2,
   output logic        res_vld,
   input  logic        res_rdy,
   output logic        res_taken,
   output logic [31:0] res_target,
   output logic [31:0] res_link,
   output logic        res_wb,
   output logic        res_trap,
   output logic        redirect,
   input  logic        redirect_ack,
   output logic [31:0] cnt_branch,
   output logic [31:0] cnt_taken
);
   localparam logic [1:0] K_BR = 2'b00, K_JAL = 2'b01, K_JALR = 2'b10;

   typedef enum logic {RUN, SQUASH} state_t;

   // ctl marks a real control transfer so retire can count it.
   typedef struct packed {
      logic        taken;
      logic [31:0] target;
      logic [31:0] link;
      logic        wb;
      logic        trap;
      logic        ctl;
   } res_t;

   state_t state_q, state_d;
   res_t   res_d, res_q;
   logic   cmp_taken;
   logic   load;
   logic   retire;

   kronos_branch u_cmp (
      .op    (dec_op),
      .rs1   (dec_rs1),
      .rs2   (dec_rs2),
      .taken (cmp_taken)
   );

   // Decode-side result: target, taken, trap and writeback qualification.
   always_comb begin
      res_d        = '0;
      res_d.link   = dec_pc + 32'd4;
      res_d.target = dec_pc + dec_imm;
      res_d.ctl    = (dec_kind != 2'b11);
      case (dec_kind)
         K_BR:    res_d.taken = cmp_taken;
         K_JAL:   res_d.taken = 1'b1;
         K_JALR: begin
            res_d.taken  = 1'b1;
            res_d.target = (dec_rs1 + dec_imm) & 32'hFFFF_FFFE;
         end
         default: res_d.taken = 1'b0;
      endcase
      res_d.trap = res_d.taken & res_d.target[1] & CATCH_MISALIGN;
      // A trapping jump must not write its link register.
      res_d.wb   = ((dec_kind == K_JAL) || (dec_kind == K_JALR)) & ~res_d.trap;
   end

   // State register; reset abandons any pending redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   // Next state and handshake. Squashed instructions never enter the result
   // register, so decode is always ready while a redirect is outstanding.
   always_comb begin
      state_d = state_q;
      dec_rdy = 1'b1;
      load    = 1'b0;
      case (state_q)
         RUN: begin
            dec_rdy = ~res_vld | res_rdy;
            load    = dec_vld & dec_rdy;
            if (load && res_d.taken && !res_d.trap) state_d = SQUASH;
         end
         SQUASH: begin
            dec_rdy = 1'b1;
            if (redirect_ack) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   assign redirect = (state_q == SQUASH);
   assign retire   = res_vld & res_rdy;

   // One-entry result register; a reload in the retire cycle avoids a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_vld <= 1'b0;
         res_q   <= '0;
      end else if (load) begin
         res_vld <= 1'b1;
         res_q   <= res_d;
      end else if (res_rdy) begin
         res_vld <= 1'b0;
      end
   end

   // Retire-time statistics, free-running with natural 32-bit wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_branch <= '0;
         cnt_taken  <= '0;
      end else if (retire) begin
         if (res_q.ctl)                  cnt_branch <= cnt_branch + 32'd1;
         if (res_q.taken && !res_q.trap) cnt_taken  <= cnt_taken + 32'd1;
      end
   end

   assign res_taken  = res_q.taken;
   assign res_target = res_q.target;
   assign res_link   = res_q.link;
   assign res_wb     = res_q.wb;
   assign res_trap   = res_q.trap;
endmodule

// File: tb/tb_kronos_branch_resolve.sv
// Self-checking bench: directed table, multi-cycle corner sequences and a
// randomized run against a behavioural model of the resolution rules.
module tb_kronos_branch_resolve;
   logic        clk = 1'b0;
   logic        rst;
   logic        dec_vld, dec_rdy;
   logic [1:0]  dec_kind;
   logic [2:0]  dec_op;
   logic [31:0] dec_pc, dec_imm, dec_rs1, dec_rs2;
   logic        res_vld, res_rdy, res_taken, res_wb, res_trap;
   logic [31:0] res_target, res_link;
   logic        redirect, redirect_ack;
   logic [31:0] cnt_branch, cnt_taken;

   always #5 clk = ~clk;

   kronos_branch_resolve #(.CATCH_MISALIGN(1'b1)) dut (
      .clk(clk), .rst(rst), .dec_vld(dec_vld), .dec_rdy(dec_rdy),
      .dec_kind(dec_kind), .dec_op(dec_op), .dec_pc(dec_pc), .dec_imm(dec_imm),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .res_vld(res_vld), .res_rdy(res_rdy),
      .res_taken(res_taken), .res_target(res_target), .res_link(res_link),
      .res_wb(res_wb), .res_trap(res_trap), .redirect(redirect),
      .redirect_ack(redirect_ack), .cnt_branch(cnt_branch), .cnt_taken(cnt_taken)
   );

   typedef struct {
      logic [1:0]  kind;
      logic [2:0]  op;
      logic [31:0] pc, imm, rs1, rs2;
      logic        taken;
      logic [31:0] target, link;
      logic        wb, trap, redir;
   } vec_t;

   typedef struct {
      logic        taken;
      logic [31:0] target, link;
      logic        wb, trap, redir, ctl;
   } exp_t;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] mb, mt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Resolution rules stated directly: compare, add, mask, misalign test.
   function automatic exp_t model(input logic [1:0] kind, input logic [2:0] op,
                                  input logic [31:0] pc, input logic [31:0] imm,
                                  input logic [31:0] rs1, input logic [31:0] rs2);
      exp_t e;
      longint sa, sb;
      sa = longint'($signed(rs1));
      sb = longint'($signed(rs2));
      e.link   = pc + 32'd4;
      e.target = pc + imm;
      e.taken  = 1'b0;
      e.ctl    = (kind != 2'd3);
      if (kind == 2'd0) begin
         if      (op == 3'd0) e.taken = (rs1 == rs2);
         else if (op == 3'd1) e.taken = (rs1 != rs2);
         else if (op == 3'd4) e.taken = (sa < sb);
         else if (op == 3'd5) e.taken = (sa >= sb);
         else if (op == 3'd6) e.taken = (longint'(rs1) < longint'(rs2));
         else if (op == 3'd7) e.taken = (longint'(rs1) >= longint'(rs2));
      end else if (kind == 2'd1) begin
         e.taken = 1'b1;
      end else if (kind == 2'd2) begin
         e.taken  = 1'b1;
         e.target = 32'((longint'(rs1) + longint'(imm)) % 64'h1_0000_0000);
         e.target[0] = 1'b0;
      end
      e.trap  = e.taken && e.target[1];
      e.wb    = (kind == 2'd1 || kind == 2'd2) && !e.trap;
      e.redir = e.taken && !e.trap;
      return e;
   endfunction

   task automatic drive(input logic [1:0] k, input logic [2:0] o, input logic [31:0] p,
                        input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
      dec_kind = k; dec_op = o; dec_pc = p; dec_imm = i; dec_rs1 = a; dec_rs2 = b;
   endtask

   vec_t tbl[11];
   exp_t mres, e;
   logic mvld, msq, erdy, retire, acc;
   int   nacc, nret;

   initial begin
      tbl[0]  = '{2'd0, 3'd0, 32'h100, 32'h40, 32'd5, 32'd5, 1, 32'h140, 32'h104, 0, 0, 1};
      tbl[1]  = '{2'd0, 3'd4, 32'h300, 32'h10, 32'hFFFFFFFF, 32'd1, 1, 32'h310, 32'h304, 0, 0, 1};
      tbl[2]  = '{2'd0, 3'd6, 32'h320, 32'h10, 32'hFFFFFFFF, 32'd1, 0, 32'h330, 32'h324, 0, 0, 0};
      tbl[3]  = '{2'd2, 3'd0, 32'h200, 32'h0, 32'h1003, 32'd0, 1, 32'h1002, 32'h204, 0, 1, 0};
      tbl[4]  = '{2'd1, 3'd0, 32'hFFFFFFF0, 32'h20, 32'd0, 32'd0, 1, 32'h10, 32'hFFFFFFF4, 1, 0, 1};
      tbl[5]  = '{2'd0, 3'd1, 32'h40, 32'h8, 32'd3, 32'd3, 0, 32'h48, 32'h44, 0, 0, 0};
      tbl[6]  = '{2'd0, 3'd5, 32'h80, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'd1, 0, 32'h70, 32'h84, 0, 0, 0};
      tbl[7]  = '{2'd0, 3'd7, 32'h80, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'd1, 1, 32'h70, 32'h84, 0, 0, 1};
      tbl[8]  = '{2'd1, 3'd0, 32'h1000, 32'h6, 32'd0, 32'd0, 1, 32'h1006, 32'h1004, 0, 1, 0};
      tbl[9]  = '{2'd3, 3'd0, 32'h500, 32'h4, 32'd0, 32'd0, 0, 32'h504, 32'h504, 0, 0, 0};
      tbl[10] = '{2'd2, 3'd0, 32'h600, 32'h10, 32'h2001, 32'd0, 1, 32'h2010, 32'h604, 1, 0, 1};

      rst = 1'b1; dec_vld = 1'b0; res_rdy = 1'b0; redirect_ack = 1'b0;
      drive(2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      #12;
      chk("rst res_vld", 32'(res_vld), 32'd0);
      chk("rst redirect", 32'(redirect), 32'd0);
      chk("rst cnt_branch", cnt_branch, 32'd0);
      chk("rst cnt_taken", cnt_taken, 32'd0);
      chk("rst dec_rdy", 32'(dec_rdy), 32'd1);
      @(posedge clk); #1; rst = 1'b0;
      mb = '0; mt = '0;

      // Directed table: accept, check result, then retire (ack returns to RUN).
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].kind, tbl[i].op, tbl[i].pc, tbl[i].imm, tbl[i].rs1, tbl[i].rs2);
         dec_vld = 1'b1;
         @(posedge clk); #1; dec_vld = 1'b0;
         chk($sformatf("v%0d res_vld", i), 32'(res_vld), 32'd1);
         chk($sformatf("v%0d taken", i), 32'(res_taken), 32'(tbl[i].taken));
         if (tbl[i].kind != 2'd3) chk($sformatf("v%0d target", i), res_target, tbl[i].target);
         chk($sformatf("v%0d link", i), res_link, tbl[i].link);
         chk($sformatf("v%0d wb", i), 32'(res_wb), 32'(tbl[i].wb));
         chk($sformatf("v%0d trap", i), 32'(res_trap), 32'(tbl[i].trap));
         chk($sformatf("v%0d redirect", i), 32'(redirect), 32'(tbl[i].redir));
         res_rdy = 1'b1; redirect_ack = 1'b1;
         @(posedge clk); #1; res_rdy = 1'b0; redirect_ack = 1'b0;
         if (tbl[i].kind != 2'd3) mb++;
         if (tbl[i].taken && !tbl[i].trap) mt++;
      end
      chk("tbl cnt_branch", cnt_branch, mb);
      chk("tbl cnt_taken", cnt_taken, mt);

      // Squash: wrong-path offers (including one in the ack cycle) are dropped.
      drive(2'd0, 3'd0, 32'h400, 32'h80, 32'd7, 32'd7); dec_vld = 1'b1;
      @(posedge clk); #1;
      drive(2'd1, 3'd0, 32'h900, 32'h40, 32'd0, 32'd0);
      #1; chk("sq dec_rdy", 32'(dec_rdy), 32'd1);
      @(posedge clk); #1;
      chk("sq redirect held", 32'(redirect), 32'd1);
      chk("sq target held", res_target, 32'h480);
      redirect_ack = 1'b1;
      @(posedge clk); #1; redirect_ack = 1'b0; dec_vld = 1'b0;
      chk("sq redirect drop", 32'(redirect), 32'd0);
      chk("sq target kept", res_target, 32'h480);
      chk("sq res_vld", 32'(res_vld), 32'd1);
      chk("sq dec_rdy run", 32'(dec_rdy), 32'd0);
      res_rdy = 1'b1;
      @(posedge clk); #1; res_rdy = 1'b0; mb++; mt++;
      chk("sq cnt_branch", cnt_branch, mb);
      chk("sq cnt_taken", cnt_taken, mt);

      // Back-pressure: 4 non-taken branches, result stalled for 3 cycles.
      nacc = 0; nret = 0;
      for (int c = 0; c < 30 && nret < 4; c++) begin
         res_rdy = (c >= 4);
         dec_vld = (nacc < 4);
         drive(2'd0, 3'd1, 32'h1000 + 32'(nacc) * 32'h10, 32'h8, 32'd9, 32'd9);
         #1;
         if (c == 2) begin
            chk("bp dec_rdy stall", 32'(dec_rdy), 32'd0);
            chk("bp first held", res_link, 32'h1004);
         end
         if (res_vld && res_rdy) begin
            chk($sformatf("bp order %0d", nret), res_link, 32'h1004 + 32'(nret) * 32'h10);
            nret++;
         end
         if (dec_vld && dec_rdy) nacc++;
         @(posedge clk); #1;
      end
      dec_vld = 1'b0; res_rdy = 1'b0;
      mb = mb + 32'd4;
      chk("bp retired", 32'(nret), 32'd4);
      chk("bp cnt_branch", cnt_branch, mb);

      // Reset in SQUASH with a held result clears everything at once.
      drive(2'd1, 3'd0, 32'h2000, 32'h100, 32'd0, 32'd0); dec_vld = 1'b1;
      @(posedge clk); #1; dec_vld = 1'b0;
      chk("rs redirect pre", 32'(redirect), 32'd1);
      rst = 1'b1; #1;
      chk("rs res_vld", 32'(res_vld), 32'd0);
      chk("rs redirect", 32'(redirect), 32'd0);
      chk("rs target", res_target, 32'd0);
      chk("rs cnt_branch", cnt_branch, 32'd0);
      chk("rs cnt_taken", cnt_taken, 32'd0);
      chk("rs dec_rdy", 32'(dec_rdy), 32'd1);
      @(posedge clk); #1; rst = 1'b0; mb = '0; mt = '0;
      drive(2'd0, 3'd1, 32'h40, 32'h8, 32'd1, 32'd1); dec_vld = 1'b1;
      @(posedge clk); #1; dec_vld = 1'b0;
      chk("rs run state", 32'(dec_rdy), 32'd0);
      chk("rs no redirect", 32'(redirect), 32'd0);
      res_rdy = 1'b1;
      @(posedge clk); #1; res_rdy = 1'b0; mb++;

      // Randomized run against the model.
      mvld = 1'b0; msq = 1'b0;
      for (int n = 0; n < 600; n++) begin
         dec_kind = 2'($urandom_range(0, 3));
         dec_op   = 3'($urandom_range(0, 7));
         dec_rs1  = $urandom;
         dec_rs2  = ($urandom_range(0, 3) == 0) ? dec_rs1 : $urandom;
         dec_pc   = $urandom & 32'hFFFF_FFFC;
         dec_imm  = ($urandom_range(0, 1) == 1) ? ($urandom & 32'h0000_0FFE) : ($urandom | 32'hFFFF_F000);
         dec_vld  = ($urandom_range(0, 3) != 0);
         res_rdy  = ($urandom_range(0, 2) != 0);
         redirect_ack = ($urandom_range(0, 3) == 0);
         #1;
         erdy = msq ? 1'b1 : (!mvld || res_rdy);
         chk("rnd dec_rdy", 32'(dec_rdy), 32'(erdy));
         chk("rnd res_vld", 32'(res_vld), 32'(mvld));
         chk("rnd redirect", 32'(redirect), 32'(msq));
         chk("rnd cnt_branch", cnt_branch, mb);
         chk("rnd cnt_taken", cnt_taken, mt);
         if (mvld) begin
            chk("rnd taken", 32'(res_taken), 32'(mres.taken));
            if (mres.ctl) chk("rnd target", res_target, mres.target);
            chk("rnd link", res_link, mres.link);
            chk("rnd wb", 32'(res_wb), 32'(mres.wb));
            chk("rnd trap", 32'(res_trap), 32'(mres.trap));
         end
         e      = model(dec_kind, dec_op, dec_pc, dec_imm, dec_rs1, dec_rs2);
         retire = mvld && res_rdy;
         acc    = dec_vld && erdy;
         if (retire) begin
            if (mres.ctl) mb++;
            if (mres.taken && !mres.trap) mt++;
         end
         if (acc && !msq) begin
            mres = e; mvld = 1'b1;
         end else if (retire) begin
            mvld = 1'b0;
         end
         if (msq) begin
            if (redirect_ack) msq = 1'b0;
         end else if (acc && e.redir) begin
            msq = 1'b1;
         end
         @(posedge clk); #1;
      end
      dec_vld = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
